block_norm: RTL and testbench



---
 rtl/norm_pkg.sv | 21 ++
 rtl/block_norm_buf.sv | 26 ++
 rtl/block_norm.sv | 101 ++++++++++
 tb/tb_block_norm.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared types and defaults for the block normalizer.
// clamp_lead saturates out-of-range leading-one indices.
package norm_pkg;

    localparam int NORM_SIZE   = 10;
    localparam int NORM_LEAD_W = 5;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic logic [NORM_LEAD_W-1:0] clamp_lead(
        input logic [NORM_LEAD_W-1:0] lead
    );
        logic [NORM_LEAD_W-1:0] top;
        top = NORM_LEAD_W'(NORM_SIZE - 1);
        return (lead > top) ? top : lead;
    endfunction

endpackage

// File: rtl/block_norm_buf.sv
// Frame buffer: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset.
module block_norm_buf #(
    parameter int SIZE  = 10,
    parameter int FRAME = 8,
    parameter int AW    = $clog2(FRAME)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [SIZE-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [SIZE-1:0] rdata
);

    logic [SIZE-1:0] mem [FRAME];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/block_norm.sv
// Block-floating-point normalizer: fill a frame, track max lead,
// then replay every sample shifted by the shared block shift.
module block_norm
    import norm_pkg::*;
#(
    parameter int SIZE   = NORM_SIZE,
    parameter int LEAD_W = NORM_LEAD_W,
    parameter int FRAME  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   in_val,
    input  logic [LEAD_W-1:0] in_lead,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIZE-1:0]   out_val,
    output logic [LEAD_W-1:0] out_shift,
    output logic              out_last
);

    localparam int AW = $clog2(FRAME);
    localparam logic [AW-1:0] LAST = AW'(FRAME - 1);
    localparam logic [LEAD_W-1:0] TOP = LEAD_W'(SIZE - 1);

    state_t            state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LEAD_W-1:0] max_lead;
    logic [LEAD_W-1:0] shift_r;
    logic [LEAD_W-1:0] lead_c;
    logic [LEAD_W-1:0] max_nxt;
    logic [SIZE-1:0]   rdata;
    logic              accept;
    logic              xfer;
    logic              is_last;

    assign lead_c  = clamp_lead(in_lead);
    assign max_nxt = (lead_c > max_lead) ? lead_c : max_lead;

    // Handshake flags come straight from the state register.
    assign in_ready  = (state == FILL);
    assign out_valid = (state == DRAIN);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign is_last   = (rd_ptr == LAST);

    assign out_val   = out_valid ? (rdata << shift_r) : '0;
    assign out_shift = out_valid ? shift_r : '0;
    assign out_last  = out_valid && is_last;

    block_norm_buf #(
        .SIZE  (SIZE),
        .FRAME (FRAME),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (in_val),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FILL;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            max_lead <= '0;
            shift_r  <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        max_lead <= max_nxt;
                        wr_ptr   <= wr_ptr + 1'b1;
                        if (wr_ptr == LAST) begin
                            wr_ptr  <= '0;
                            shift_r <= TOP - max_nxt;
                            state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        if (is_last) begin
                            rd_ptr   <= '0;
                            max_lead <= '0;
                            state    <= FILL;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_block_norm.sv
// Scoreboard bench for block_norm: expected samples are queued when a
// frame is sent and popped as the DUT drains it.
module tb_block_norm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_val;
    logic [4:0] in_lead;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_val;
    logic [4:0] out_shift;
    logic       out_last;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [9:0] v;
        logic [4:0] s;
        logic       l;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    block_norm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_val    (in_val),
        .in_lead   (in_lead),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_val   (out_val),
        .out_shift (out_shift),
        .out_last  (out_last)
    );

    // Sends n samples; a complete frame also queues its expected output.
    task automatic send_frame(input logic [9:0] v[8],
                              input logic [4:0] l[8], input int n);
        int   m;
        int   lc;
        int   sh;
        logic [19:0] wide;
        exp_t e;
        m = 0;
        for (int i = 0; i < 8; i++) begin
            lc = (int'(l[i]) > 9) ? 9 : int'(l[i]);
            if (lc > m) m = lc;
        end
        sh = 9 - m;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_fill[%0d] got=%b want=1", i, in_ready);
            end
            in_valid = 1'b1;
            in_val   = v[i];
            in_lead  = l[i];
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (n == 8) begin
            for (int i = 0; i < 8; i++) begin
                wide = {10'b0, v[i]} << sh;
                e.v  = wide[9:0];
                e.s  = 5'(sh);
                e.l  = (i == 7);
                q.push_back(e);
            end
        end
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0 repeating.
    task automatic drain(input int mode, input int nmax,
                         output int busy, output logic [4:0] shv);
        int   n;
        int   cyc;
        logic rdy;
        logic held;
        logic [9:0] hv;
        logic [4:0] hs;
        logic hl;
        exp_t e;
        n    = 0;
        cyc  = 0;
        busy = 0;
        held = 1'b0;
        shv  = '0;
        hv   = '0;
        hs   = '0;
        hl   = 1'b0;
        while (n < nmax && cyc < 200) begin
            if (cyc != 0) @(negedge clk);
            rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (in_ready === 1'b0) busy++;
            if (held) begin
                checks++;
                if ({out_valid, out_val, out_shift, out_last} !==
                    {1'b1, hv, hs, hl}) begin
                    errors++;
                    $display("FAIL hold got=%h/%h/%b want=%h/%h/%b",
                             out_val, out_shift, out_last, hv, hs, hl);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_drain got=%b want=0", in_ready);
                end
            end
            out_ready = rdy;
            held = 1'b0;
            if (out_valid === 1'b1 && rdy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_output got=%h want=none", out_val);
                end else begin
                    e = q.pop_front();
                    if ({out_val, out_shift, out_last} !== {e.v, e.s, e.l}) begin
                        errors++;
                        $display("FAIL out[%0d] got=%h/%h/%b want=%h/%h/%b",
                                 n, out_val, out_shift, out_last, e.v, e.s, e.l);
                    end
                end
                shv = out_shift;
                n++;
            end else if (out_valid === 1'b1) begin
                held = 1'b1;
                hv   = out_val;
                hs   = out_shift;
                hl   = out_last;
            end
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        if (n < nmax) begin
            errors++;
            $display("FAIL drain_timeout got=%0d want=%0d", n, nmax);
        end
        if (nmax == 8) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL after_drain got=%b/%b want=1/0",
                         in_ready, out_valid);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({in_ready, out_valid, out_val, out_shift, out_last} !==
            {1'b1, 1'b0, 10'h0, 5'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset got=%b/%b/%h/%h/%b want=1/0/000/00/0",
                     in_ready, out_valid, out_val, out_shift, out_last);
        end
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic chk_shift(input string nm, input logic [4:0] got,
                             input logic [4:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic test_basic();
        logic [9:0] v[8] = '{10'h001, 10'h010, 10'h040, 10'h003,
                             10'h000, 10'h020, 10'h002, 10'h008};
        logic [4:0] l[8] = '{5'd0, 5'd4, 5'd6, 5'd1, 5'd0, 5'd5, 5'd1, 5'd3};
        int busy;
        logic [4:0] sh;
        send_frame(v, l, 8);
        drain(0, 8, busy, sh);
        chk_shift("basic_shift", sh, 5'd3);
        checks++;
        if (busy != 8) begin
            errors++;
            $display("FAIL basic_busy got=%0d want=8", busy);
        end
    endtask

    task automatic test_zero();
        logic [9:0] v[8] = '{default: 10'h000};
        logic [4:0] l[8] = '{default: 5'd0};
        int busy;
        logic [4:0] sh;
        send_frame(v, l, 8);
        drain(0, 8, busy, sh);
        chk_shift("zero_shift", sh, 5'd9);
    endtask

    task automatic test_full();
        logic [9:0] v[8] = '{10'h3FF, 10'h155, 10'h001, 10'h0F0,
                             10'h200, 10'h000, 10'h07F, 10'h2AA};
        logic [4:0] l[8] = '{5'd9, 5'd8, 5'd0, 5'd7, 5'd9, 5'd0, 5'd6, 5'd9};
        int busy;
        logic [4:0] sh;
        send_frame(v, l, 8);
        drain(0, 8, busy, sh);
        chk_shift("full_shift", sh, 5'd0);
    endtask

    task automatic test_backpressure();
        logic [9:0] v[8] = '{10'h001, 10'h010, 10'h040, 10'h003,
                             10'h000, 10'h020, 10'h002, 10'h008};
        logic [4:0] l[8] = '{5'd0, 5'd4, 5'd6, 5'd1, 5'd0, 5'd5, 5'd1, 5'd3};
        int busy;
        logic [4:0] sh;
        send_frame(v, l, 8);
        drain(1, 8, busy, sh);
        chk_shift("bp_shift", sh, 5'd3);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL bp_leftover got=%0d want=0", q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] big[8] = '{default: 10'h3FF};
        logic [4:0] bigl[8] = '{default: 5'd9};
        logic [9:0] v[8] = '{default: 10'h004};
        logic [4:0] l[8] = '{default: 5'd2};
        int busy;
        logic [4:0] sh;
        send_frame(big, bigl, 5);
        do_reset();
        send_frame(big, bigl, 8);
        drain(0, 3, busy, sh);
        do_reset();
        send_frame(v, l, 8);
        drain(0, 8, busy, sh);
        chk_shift("rst_shift", sh, 5'd7);
    endtask

    task automatic test_saturation();
        logic [9:0] v[8] = '{default: 10'h001};
        logic [4:0] l[8] = '{5'd0, 5'd0, 5'd15, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        int busy;
        logic [4:0] sh;
        send_frame(v, l, 8);
        drain(0, 8, busy, sh);
        chk_shift("sat_shift", sh, 5'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_val    = '0;
        in_lead   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_zero();
        test_full();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
